// File: rtl/regwrite_pkg.sv
// Shared mode encodings and FSM state type for the register write bank.
package regwrite_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_PRIO   = 2'b01;
  localparam logic [1:0] MODE_FILL   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

endpackage

// File: rtl/regwrite_bank_prio_onehot.sv
// Keeps only the lowest set bit of req; zero in gives zero out.
// Combinational, no latency, no backpressure.
module prio_onehot #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  // Two's complement isolates the lowest set bit.
  assign gnt = req & (~req + N'(1));

endmodule

// File: rtl/regwrite_bank.sv
// Bank of NREG x WIDTH registers with direct, priority and sequenced fill writes; 1-cycle write latency.
// No backpressure: fill runs to completion once started and ignores mode/ctrl/start meanwhile.
module regwrite_bank
  import regwrite_pkg::*;
#(
  parameter int               NREG    = 4,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [NREG-1:0]       ctrl,
  input  logic [WIDTH-1:0]      in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [NREG*WIDTH-1:0] rout
);

  localparam int PW = (NREG > 1) ? $clog2(NREG) : 1;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic            done_nxt;
  logic [NREG-1:0] we;
  logic [NREG-1:0] prio_we;
  logic [NREG-1:0] fill_we;

  prio_onehot #(.N(NREG)) u_prio (
    .req (ctrl),
    .gnt (prio_we)
  );

  always_comb begin
    fill_we = '0;
    for (int i = 0; i < NREG; i++) begin
      fill_we[i] = (ptr == PW'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    done_nxt  = 1'b0;
    we        = '0;
    case (state)
      ST_IDLE: begin
        case (mode)
          MODE_DIRECT: we = ctrl;
          MODE_PRIO:   we = prio_we;
          MODE_FILL: begin
            if (start) begin
              state_nxt = ST_FILL;
              ptr_nxt   = '0;
            end
          end
          default: we = '0;
        endcase
      end
      ST_FILL: begin
        we = fill_we;
        if (ptr == PW'(NREG - 1)) begin
          ptr_nxt   = '0;
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          ptr_nxt = ptr + PW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
      done  <= 1'b0;
      rout  <= {NREG{RST_VAL}};
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      done  <= done_nxt;
      for (int i = 0; i < NREG; i++) begin
        if (we[i]) rout[i*WIDTH +: WIDTH] <= in;
      end
    end
  end

  assign busy = (state == ST_FILL);

endmodule

// File: tb/tb_regwrite_bank.sv
// Directed bench for regwrite_bank: a 4x8 bank for the main functions and a 2x8 bank for the fill boundary.
module tb_regwrite_bank;

  logic        clk = 1'b0;
  logic        rst, start, busy, done;
  logic [1:0]  mode;
  logic [3:0]  ctrl;
  logic [7:0]  in;
  logic [31:0] rout;

  logic        rst2, start2, busy2, done2;
  logic [1:0]  mode2;
  logic [1:0]  ctrl2;
  logic [7:0]  in2;
  logic [15:0] rout2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regwrite_bank #(.NREG(4), .WIDTH(8), .RST_VAL(8'h00)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .mode  (mode),
    .ctrl  (ctrl),
    .in    (in),
    .start (start),
    .busy  (busy),
    .done  (done),
    .rout  (rout)
  );

  regwrite_bank #(.NREG(2), .WIDTH(8), .RST_VAL(8'h5A)) u_dut2 (
    .clk   (clk),
    .rst   (rst2),
    .mode  (mode2),
    .ctrl  (ctrl2),
    .in    (in2),
    .start (start2),
    .busy  (busy2),
    .done  (done2),
    .rout  (rout2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mode = 2'b11; ctrl = '0; in = '0; start = 1'b0;
    rst2 = 1'b1; mode2 = 2'b11; ctrl2 = '0; in2 = '0; start2 = 1'b0;
    tick();
    chk("rst_rout", rout, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst2_rout", rout2, 16'h5A5A);
    rst = 1'b0; rst2 = 1'b0;

    // direct writes
    mode = 2'b00; ctrl = 4'b0001; in = 8'hA5; tick();
    chk("dir_lane0", rout, 32'h000000A5);
    ctrl = 4'b0100; in = 8'h3C; tick();
    chk("dir_lane2", rout, 32'h003C00A5);
    chk("dir_busy", busy, 1'b0);
    chk("dir_done", done, 1'b0);
    ctrl = 4'b0000; in = 8'hFF; tick();
    chk("dir_zero", rout, 32'h003C00A5);
    ctrl = 4'b1010; in = 8'h11; tick();
    chk("dir_multi", rout, 32'h113C11A5);

    // priority writes
    mode = 2'b01; ctrl = 4'b1010; in = 8'h22; tick();
    chk("prio_low", rout, 32'h113C22A5);
    ctrl = 4'b0000; in = 8'h77; tick();
    chk("prio_zero", rout, 32'h113C22A5);

    // hold mode ignores ctrl and start
    mode = 2'b11; ctrl = 4'b1111; start = 1'b1; in = 8'h99; tick();
    chk("hold_rout", rout, 32'h113C22A5);
    chk("hold_busy", busy, 1'b0);

    // fill with distractions mid-sequence
    mode = 2'b10; ctrl = 4'b0000; start = 1'b1; in = 8'hEE; tick();  // edge k
    chk("fill_start_nowrite", rout, 32'h113C22A5);
    chk("fill_busy_k", busy, 1'b1);
    start = 1'b0; in = 8'h01; tick();                               // k+1
    chk("fill_busy_k1", busy, 1'b1);
    chk("fill_r0", rout, 32'h113C2201);
    mode = 2'b00; ctrl = 4'b1111; start = 1'b1; in = 8'h02; tick();   // k+2
    chk("fill_busy_k2", busy, 1'b1);
    chk("fill_ign_ctrl", rout, 32'h113C0201);
    mode = 2'b10; ctrl = 4'b0000; start = 1'b1; in = 8'h03; tick();   // k+3
    chk("fill_busy_k3", busy, 1'b1);
    chk("fill_done_k3", done, 1'b0);
    mode = 2'b11; start = 1'b0; in = 8'h04; tick();                  // k+4
    chk("fill_rout", rout, 32'h04030201);
    chk("fill_busy_k4", busy, 1'b0);
    chk("fill_done_k4", done, 1'b1);

    // back-to-back start at k+5, then reset two edges in
    mode = 2'b10; start = 1'b1; in = 8'h55; tick();                  // k' = k+5
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_done", done, 1'b0);
    start = 1'b0; in = 8'hAA; tick();                                // k'+1
    chk("b2b_r0", rout, 32'h040302AA);
    rst = 1'b1; in = 8'hBB; tick();                                  // k'+2
    rst = 1'b0; mode = 2'b11;
    chk("rstfill_rout", rout, 32'h0);
    chk("rstfill_busy", busy, 1'b0);
    chk("rstfill_done", done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstfill_nodone", {busy, done}, 2'b00);
    end

    // fresh fill after the aborted one
    mode = 2'b10; start = 1'b1; tick();
    start = 1'b0; mode = 2'b11;
    in = 8'h10; tick();
    in = 8'h20; tick();
    in = 8'h30; tick();
    in = 8'h40; tick();
    chk("refill_rout", rout, 32'h40302010);
    chk("refill_done", done, 1'b1);
    tick();
    chk("refill_done_pulse", done, 1'b0);

    // NREG=2 boundary
    mode2 = 2'b10; start2 = 1'b1; in2 = 8'hEE; tick();
    chk("n2_busy_k", busy2, 1'b1);
    start2 = 1'b0; mode2 = 2'b11; in2 = 8'h05; tick();
    chk("n2_busy_k1", busy2, 1'b1);
    chk("n2_done_k1", done2, 1'b0);
    in2 = 8'h06; tick();
    chk("n2_rout", rout2, 16'h0605);
    chk("n2_done_k2", done2, 1'b1);
    chk("n2_busy_k2", busy2, 1'b0);
    chk("n2_ptr_wrap", u_dut2.ptr, 1'b0);
    tick();
    chk("n2_done_pulse", done2, 1'b0);
    mode2 = 2'b10; start2 = 1'b1; tick();
    start2 = 1'b0; mode2 = 2'b11; in2 = 8'hC1; tick();
    in2 = 8'hC2; tick();
    chk("n2_refill", rout2, 16'hC2C1);
    chk("n2_refill_done", done2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regwrite_bank.md
# regwrite_bank

Parametrised successor of the single-bit, four-lane control-selected register write block: a bank of NREG registers, each WIDTH bits, loaded from a shared input bus. It adds a priority-select mode and a sequenced fill mode (start/busy/done handshake, walking write pointer) on top of the direct one-hot write. It sits between control logic and downstream consumers that read the whole bank in parallel.

## Interface
- NREG, 4: number of registers; legal range 2..32.
- WIDTH, 1: bits per register; legal range 1..64.
- RST_VAL, 0: reset value of every register, WIDTH bits.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- mode  in  2  00 direct, 01 priority, 10 fill, 11 hold.
- ctrl  in  NREG  lane select; bit i addresses register i.
- in  in  WIDTH  write data, shared by all lanes.
- start  in  1  fill request; acted on only in mode 10 while idle.
- busy  out  1  high while a fill sequence runs.
- done  out  1  one-cycle pulse when a fill completes.
- rout  out  NREG*WIDTH  register bank; register i at bits [i*WIDTH +: WIDTH].

## Operation
- Reset at an edge with rst=1: every register = RST_VAL; state IDLE; ptr=0; busy=0; done=0. Reset overrides everything, including a fill in progress.
- State machine, two states:
  - IDLE: act on mode (below). busy=0.
  - FILL: each edge writes `in` to register ptr. ptr increments. At ptr==NREG-1: write, ptr resets to 0, move to IDLE, assert done for one cycle.
- IDLE, mode 00 (direct): every register i with ctrl[i]=1 gets `in`. Multiple set bits write all of them. ctrl=0 writes nothing.
- IDLE, mode 01 (priority): only the lowest-index set bit of ctrl is written. ctrl=0 writes nothing.
- IDLE, mode 10 (fill): ctrl is ignored. start=1 moves to FILL with ptr=0. No register write occurs on the start edge.
- IDLE, mode 11: no writes; start ignored.
- During FILL, mode, ctrl and start are ignored: no restart, no abort, no mode change mid-sequence.
- Unwritten registers hold their value in all modes.
- ptr width is $clog2(NREG). ptr never exceeds NREG-1. Wrap to 0 at sequence end.

## Timing
- Direct and priority writes: data presented at edge k appears on rout after edge k (1-cycle latency, no combinational path from in to rout).
- Fill, with start sampled at edge k:
  - register 0 is written at edge k+1;
  - register j is written at edge k+1+j;
  - the last register is written at edge k+NREG.
- busy: 1 after edge k through edge k+NREG-1, 0 after edge k+NREG.
- done: 1 only for the cycle following edge k+NREG. done=1 always coincides with busy=0.
- A new start is accepted at edge k+NREG+1 at the earliest, giving back-to-back fills with one idle cycle between them.
- rst=1 on any fill edge: busy=0 and done=0 on the next cycle; no done pulse is produced for the aborted fill.

## Structure
- Package regwrite_pkg holds:
  - mode constants MODE_DIRECT=2'b00, MODE_PRIO=2'b01, MODE_FILL=2'b10, MODE_HOLD=2'b11;
  - state enum {ST_IDLE, ST_FILL}.
- One sub-module, prio_onehot (parameter N): NREG-bit input to a one-hot output with only the lowest set bit kept, all-zero in gives all-zero out. Purely combinational; used in mode 01.
- Top level: state register, ptr counter, per-register write-enable vector, and the bank as NREG×WIDTH flops.

## Test plan
- Reset then direct write, NREG=4 WIDTH=8: rst 1 cycle, mode=00, ctrl=0001 in=8'hA5, then ctrl=0100 in=8'h3C → rout=32'h003C00A5; busy=0, done=0 throughout.
- Direct write to multiple lanes vs priority write: mode=00 ctrl=1010 in=8'h11 → lanes 1 and 3 =8'h11. Then mode=01 ctrl=1010 in=8'h22 → lane 1 =8'h22, lane 3 stays 8'h11.
- Fill sequence: mode=10, start pulse at edge k, in=8'h01,02,03,04 on edges k+1..k+4 → rout=32'h04030201. busy high for exactly 4 cycles. done high one cycle after edge k+4.
- Ignored inputs during fill: mode=00, ctrl=1111 and a second start mid-fill → no extra writes, no restart, done fires exactly once on schedule.
- Reset mid-fill: rst at edge k+2 → rout all RST_VAL, busy=0, done never asserts. A new start then runs a full fill normally.
- Hold mode and boundary: mode=11 with ctrl=1111 and start=1 → rout unchanged, busy=0. NREG=2 fill → done after edge k+2 and ptr wraps to 0.
